// File: rtl/branch_outcome_tracker.sv
// -----------------------------------------------------------------------------
// branch_outcome_tracker
//
// Resolution-side partner of the local branch predictor. Each prediction made
// at fetch (table index plus predicted direction) is queued in order. When the
// oldest branch resolves in EX, its entry is popped and the predictor table is
// trained through a registered update port. A registered mispredict pulse is
// raised when the actual direction differs from the prediction, and every
// younger (wrong-path) entry is discarded in the same cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push              fetch issued a predicted branch this cycle
//   push_idx          predictor index used for that branch
//   push_pred         predicted direction (1 = taken)
//   resolve           oldest in-flight branch resolved this cycle
//   resolve_taken     actual direction of the resolving branch
//   flush             external pipeline flush; discard all entries
//   upd_write         predictor table write strobe (1-cycle pulse)
//   upd_idx           predictor table write index (held between writes)
//   upd_outcome       actual outcome to train with (held between writes)
//   mispredict        1-cycle pulse: resolved branch was mispredicted
//   full, empty       occupancy flags derived from count
//   count             occupancy, 0..DEPTH
//   overflow          sticky: push dropped while full
//   underflow         sticky: resolve seen while empty
// -----------------------------------------------------------------------------
module branch_outcome_tracker #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [IDX_W-1:0]           push_idx,
   input  logic                       push_pred,
   input  logic                       resolve,
   input  logic                       resolve_taken,
   input  logic                       flush,
   output logic                       upd_write,
   output logic [IDX_W-1:0]           upd_idx,
   output logic                       upd_outcome,
   output logic                       mispredict,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Entry storage
   logic [IDX_W-1:0] idx_mem [DEPTH];
   logic             pred_mem [DEPTH];

   // Control state
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   // Registered update port
   logic             upd_write_q;
   logic [IDX_W-1:0] upd_idx_q;
   logic             upd_outcome_q;
   logic             mispredict_q;

   // Per-cycle decode
   logic             pop_valid;
   logic             head_pred;
   logic [IDX_W-1:0] head_idx;
   logic             mis;
   logic             squash;
   logic             push_ok;

   assign head_idx  = idx_mem[head_q];
   assign head_pred = pred_mem[head_q];
   assign pop_valid = resolve && (count_q != '0);
   assign mis       = pop_valid && (head_pred != resolve_taken);
   // A mispredict or flush makes any same-cycle push wrong-path.
   assign squash    = mis || flush;
   // When full, a same-cycle pop frees the slot the push needs.
   assign push_ok   = push && !squash && ((count_q != DEPTH_C) || pop_valid);

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (pop_valid) begin
         head_d = head_q + PTR_W'(1);
      end

      if (resolve && (count_q == '0)) begin
         underflow_d = 1'b1;
      end

      // Only a genuine capacity drop counts as overflow, never a squashed push.
      if (push && !squash && !push_ok) begin
         overflow_d = 1'b1;
      end

      if (squash) begin
         // Everything younger than the (possibly popped) head is discarded.
         tail_d  = head_d;
         count_d = '0;
      end else begin
         if (push_ok) begin
            tail_d = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_valid);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
         upd_write_q   <= 1'b0;
         upd_idx_q     <= '0;
         upd_outcome_q <= 1'b0;
         mispredict_q  <= 1'b0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
         upd_write_q   <= pop_valid;
         mispredict_q  <= mis;
         if (pop_valid) begin
            upd_idx_q     <= head_idx;
            upd_outcome_q <= resolve_taken;
         end
      end
   end

   // NOTE: entry storage is deliberately not reset; occupancy is tracked by
   // count, so stale contents are never observed and the array maps to RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         idx_mem[tail_q]  <= push_idx;
         pred_mem[tail_q] <= push_pred;
      end
   end

   assign upd_write   = upd_write_q;
   assign upd_idx     = upd_idx_q;
   assign upd_outcome = upd_outcome_q;
   assign mispredict  = mispredict_q;
   assign count       = count_q;
   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: doc/branch_outcome_tracker.md
Name: branch_outcome_tracker

Overview:
- Resolution-side partner of the local branch predictor.
- At fetch, records each prediction (table index plus predicted direction) in an in-order FIFO. When the branch resolves in EX, it pops the oldest entry and drives the predictor-table update port (write, index, actual outcome).
- Raises a registered mispredict pulse when the actual direction differs from the prediction, and discards younger wrong-path entries.
- Sits between the fetch-stage predictor read path and the EX-stage branch comparator.

Parameters:
- DEPTH, 4, number of in-flight predictions tracked (power of two, ≥2).
- IDX_W, 10, predictor table index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- push  in  1  fetch issued a predicted branch this cycle
- push_idx  in  IDX_W  predictor index used for that branch
- push_pred  in  1  predicted direction (1 = taken)
- resolve  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual direction of the resolving branch
- flush  in  1  external pipeline flush (trap/jump); discard all entries
- upd_write  out  1  predictor table write strobe
- upd_idx  out  IDX_W  predictor table write index
- upd_outcome  out  1  actual outcome to train with
- mispredict  out  1  one-cycle pulse: resolved branch was mispredicted
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: push dropped while full
- underflow  out  1  sticky: resolve seen while empty

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - head/tail pointers and count go to 0; empty=1, full=0.
  - upd_write, upd_idx, upd_outcome, mispredict, overflow and underflow all go to 0.
  - Entry contents are don't-care.
- Storage: circular buffer of DEPTH entries, each {idx, pred}. Pointers wrap modulo DEPTH. full and empty are derived from count, never from pointer equality alone.
- Push: when push=1 and the entry is accepted, write {push_idx, push_pred} at tail and advance tail.
  - Push is accepted if count<DEPTH, or if count==DEPTH and a valid resolve pops in the same cycle.
  - Otherwise the push is dropped and overflow is set.
- Resolve: when resolve=1 and count>0, read the head entry combinationally and advance head.
  - Next cycle: upd_write=1, upd_idx=head.idx, upd_outcome=resolve_taken, mispredict=(head.pred != resolve_taken).
  - Outputs are registered, so latency is 1 cycle from resolve to update/mispredict. upd_write and mispredict are single-cycle pulses; upd_idx and upd_outcome hold their last values when upd_write=0.
- Resolve with count==0: no update, no pop, underflow is set.
- Mispredict squash: if the resolving entry mispredicts, all younger entries are discarded in that same cycle.
  - Set tail=head+1 (post-pop head), count=0.
  - A push in the same cycle is dropped because it is wrong-path. A dropped wrong-path push does not set overflow.
- Flush: flush=1 clears all entries (count=0, tail=head).
  - A simultaneous valid resolve is still processed first: the update is emitted next cycle, and mispredict is emitted if applicable.
  - A simultaneous push is dropped, and overflow is not set.
- Push and resolve in the same cycle with a correct prediction: count is unchanged and both operations take effect.
- overflow and underflow are cleared only by rst.

Test Plan:
- Reset then idle: empty=1, count=0, upd_write=0, mispredict=0, overflow=0, underflow=0.
- Push {0x155,1}, next cycle resolve taken=1 → one cycle later upd_write=1, upd_idx=0x155, upd_outcome=1, mispredict=0; count returns to 0.
- Push {0x001,0},{0x002,1},{0x003,1}, then resolve taken=1 → upd_idx=0x001, upd_outcome=1, mispredict=1; count=0, empty=1. A following resolve sets underflow=1 and produces no upd_write.
- Fill 4 entries (full=1). A 5th push alone sets overflow=1 and leaves count at 4. Then push {0x3FF,0} together with a correct resolve → count stays 4. Drain with 4 correct resolves: upd_idx sequence is 2nd,3rd,4th pushed, then 0x3FF, confirming pointer wrap.
- Two entries present; assert resolve (correct) plus flush plus push in one cycle → upd_write=1 with the head idx, mispredict=0; count=0; overflow stays 0.
- Assert rst asynchronously mid-cycle with 3 entries and upd_write high → all outputs drop to 0 immediately, without waiting for a clock edge; count=0.
